axi_lite_buf: RTL

- Register slice between an AXI-Lite master-side channel and a slave-side channel.
- Breaks timing paths on all five channels (AW, W, B, AR, R). Each channel independently selects bypass, half (1-entry) or full (2-entry skid) buffering.
- Drop-in replacement for a plain channel join wherever a long route or crossbar boundary needs registering.

---
 rtl/axi_lite_buf_pkg.sv | 34 +++
 rtl/axi_lite_channel.sv | 47 ++++
 rtl/axi_lite_buf_stage.sv | 140 ++++++++++++++
 rtl/axi_lite_buf.sv | 83 ++++++++
 4 files changed

// File: rtl/axi_lite_buf_pkg.sv
// Shared definitions for the AXI-Lite register slice.
// Provides buffering-mode encodings, channel identifiers and a helper that
// returns the packed payload width of each channel.
package axi_lite_buf_pkg;

    localparam int unsigned MODE_BYPASS = 0;
    localparam int unsigned MODE_HALF   = 1;
    localparam int unsigned MODE_FULL   = 2;

    localparam int unsigned PROT_W = 3;
    localparam int unsigned RESP_W = 2;

    typedef enum logic [2:0] {
        CH_AW,
        CH_W,
        CH_B,
        CH_AR,
        CH_R
    } chan_e;

    // Packed payload width of one channel for the given bus widths.
    function automatic int unsigned payload_width(input chan_e ch,
                                                  input int unsigned addr_w,
                                                  input int unsigned data_w);
        case (ch)
            CH_AW, CH_AR: return addr_w + PROT_W;
            CH_W:         return data_w + data_w / 8;
            CH_B:         return RESP_W;
            CH_R:         return data_w + RESP_W;
            default:      return 1;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle (AW, W, B, AR, R).
// Modport master: initiator view. Modport slave: target view.
interface axi_lite_channel #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [2:0]                aw_prot;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;

    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [2:0]                ar_prot;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, input  aw_ready,
        output w_valid,  w_data,  w_strb,  input  w_ready,
        input  b_valid,  b_resp,           output b_ready,
        output ar_valid, ar_addr, ar_prot, input  ar_ready,
        input  r_valid,  r_data,  r_resp,  output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot, output aw_ready,
        input  w_valid,  w_data,  w_strb,  output w_ready,
        output b_valid,  b_resp,           input  b_ready,
        input  ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid,  r_data,  r_resp,  input  r_ready
    );

endinterface

// File: rtl/axi_lite_buf_stage.sv
// Generic valid/ready pipeline stage: bypass, half (1 entry) or full skid (2 entries).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    producer handshake, in_data payload
//   out_valid/out_ready  consumer handshake, out_data payload
module axi_lite_buf_stage
    import axi_lite_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = MODE_FULL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (MODE > MODE_FULL) begin : g_mode_chk
        $fatal(1, "axi_lite_buf_stage: MODE %0d is not 0, 1 or 2", MODE);
    end

    if (MODE == MODE_BYPASS) begin : g_bypass
        // Pure wires; the clock and reset are intentionally unused here.
        logic w_unused;
        assign w_unused  = clk ^ rst;
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;

    end else if (MODE == MODE_HALF) begin : g_half
        logic             r_full;
        logic             r_in_ready;
        logic [WIDTH-1:0] r_data;
        logic             w_in_xfer;
        logic             w_out_xfer;
        logic             w_full_nxt;

        assign w_in_xfer  = in_valid && r_in_ready;
        assign w_out_xfer = r_full && out_ready;

        // Ready is low while full, so fill and drain never coincide.
        always_comb begin
            w_full_nxt = r_full;
            if (w_in_xfer) begin
                w_full_nxt = 1'b1;
            end else if (w_out_xfer) begin
                w_full_nxt = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_full     <= 1'b0;
                r_in_ready <= 1'b0;
            end else begin
                r_full     <= w_full_nxt;
                r_in_ready <= !w_full_nxt;
            end
        end

        always_ff @(posedge clk) begin
            if (w_in_xfer) begin
                r_data <= in_data;
            end
        end

        assign in_ready  = r_in_ready;
        assign out_valid = r_full;
        assign out_data  = r_data;

    end else begin : g_full
        logic             r_out_valid;
        logic             r_skid_valid;
        logic             r_in_ready;
        logic [WIDTH-1:0] r_out_data;
        logic [WIDTH-1:0] r_skid_data;
        logic             w_in_xfer;
        logic             w_out_valid_nxt;
        logic             w_skid_valid_nxt;
        logic             w_load_out;
        logic             w_out_from_skid;
        logic             w_load_skid;

        assign w_in_xfer = in_valid && r_in_ready;

        // Output register refills from skid first, then from the input;
        // a beat arriving while the output is stalled parks in skid.
        always_comb begin
            w_out_valid_nxt  = r_out_valid;
            w_skid_valid_nxt = r_skid_valid;
            w_load_out       = 1'b0;
            w_out_from_skid  = 1'b0;
            w_load_skid      = 1'b0;
            if (!r_out_valid || out_ready) begin
                if (r_skid_valid) begin
                    w_out_valid_nxt  = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                    w_load_out       = 1'b1;
                    w_out_from_skid  = 1'b1;
                end else begin
                    w_out_valid_nxt  = w_in_xfer;
                    w_load_out       = w_in_xfer;
                end
            end else if (w_in_xfer) begin
                w_skid_valid_nxt = 1'b1;
                w_load_skid      = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b0;
            end else begin
                r_out_valid  <= w_out_valid_nxt;
                r_skid_valid <= w_skid_valid_nxt;
                r_in_ready   <= !w_skid_valid_nxt;
            end
        end

        always_ff @(posedge clk) begin
            if (w_load_out) begin
                r_out_data <= w_out_from_skid ? r_skid_data : in_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
            end
        end

        assign in_ready  = r_in_ready;
        assign out_valid = r_out_valid;
        assign out_data  = r_out_data;
    end

endmodule

// File: rtl/axi_lite_buf.sv
// AXI-Lite register slice: one independently configurable stage per channel.
// Ports:
//   clk     clock
//   rst     synchronous active-high reset
//   master  upstream side, driven by the initiator
//   slave   downstream side, drives the target
module axi_lite_buf
    import axi_lite_buf_pkg::*;
#(
    parameter int unsigned AW_MODE = MODE_FULL,
    parameter int unsigned W_MODE  = MODE_FULL,
    parameter int unsigned B_MODE  = MODE_FULL,
    parameter int unsigned AR_MODE = MODE_FULL,
    parameter int unsigned R_MODE  = MODE_FULL
) (
    input  logic            clk,
    input  logic            rst,
    axi_lite_channel.slave  master,
    axi_lite_channel.master slave
);

    localparam int unsigned ADDR_W = master.ADDR_WIDTH;
    localparam int unsigned DATA_W = master.DATA_WIDTH;
    localparam int unsigned AW_W   = payload_width(CH_AW, ADDR_W, DATA_W);
    localparam int unsigned W_W    = payload_width(CH_W,  ADDR_W, DATA_W);
    localparam int unsigned B_W    = payload_width(CH_B,  ADDR_W, DATA_W);
    localparam int unsigned AR_W   = payload_width(CH_AR, ADDR_W, DATA_W);
    localparam int unsigned R_W    = payload_width(CH_R,  ADDR_W, DATA_W);

    if (master.ADDR_WIDTH != slave.ADDR_WIDTH ||
        master.DATA_WIDTH != slave.DATA_WIDTH) begin : g_width_chk
        $fatal(1, "axi_lite_buf: master/slave interface widths differ");
    end

    logic [AW_W-1:0] w_aw_in, w_aw_out;
    logic [W_W-1:0]  w_w_in,  w_w_out;
    logic [B_W-1:0]  w_b_in,  w_b_out;
    logic [AR_W-1:0] w_ar_in, w_ar_out;
    logic [R_W-1:0]  w_r_in,  w_r_out;

    // Payload pack/unpack; B and R travel slave -> master.
    assign w_aw_in = {master.aw_addr, master.aw_prot};
    assign {slave.aw_addr, slave.aw_prot} = w_aw_out;
    assign w_w_in  = {master.w_data, master.w_strb};
    assign {slave.w_data, slave.w_strb} = w_w_out;
    assign w_b_in  = slave.b_resp;
    assign master.b_resp = w_b_out;
    assign w_ar_in = {master.ar_addr, master.ar_prot};
    assign {slave.ar_addr, slave.ar_prot} = w_ar_out;
    assign w_r_in  = {slave.r_data, slave.r_resp};
    assign {master.r_data, master.r_resp} = w_r_out;

    axi_lite_buf_stage #(.WIDTH(AW_W), .MODE(AW_MODE)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(master.aw_valid), .in_ready(master.aw_ready), .in_data(w_aw_in),
        .out_valid(slave.aw_valid), .out_ready(slave.aw_ready), .out_data(w_aw_out)
    );

    axi_lite_buf_stage #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(master.w_valid), .in_ready(master.w_ready), .in_data(w_w_in),
        .out_valid(slave.w_valid), .out_ready(slave.w_ready), .out_data(w_w_out)
    );

    axi_lite_buf_stage #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(slave.b_valid), .in_ready(slave.b_ready), .in_data(w_b_in),
        .out_valid(master.b_valid), .out_ready(master.b_ready), .out_data(w_b_out)
    );

    axi_lite_buf_stage #(.WIDTH(AR_W), .MODE(AR_MODE)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(master.ar_valid), .in_ready(master.ar_ready), .in_data(w_ar_in),
        .out_valid(slave.ar_valid), .out_ready(slave.ar_ready), .out_data(w_ar_out)
    );

    axi_lite_buf_stage #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(slave.r_valid), .in_ready(slave.r_ready), .in_data(w_r_in),
        .out_valid(master.r_valid), .out_ready(master.r_ready), .out_data(w_r_out)
    );

endmodule
